// File: rtl/outbuf_drain.sv
// Column output FIFO: discards the first SKIP pushes after reset/flush, then buffers
// results and drains them in order over a valid/ready handshake, flagging overflow.
module outbuf_drain #(
    parameter int unsigned WORDLEN = 16,
    parameter int unsigned BUFSIZE = 10,
    parameter int unsigned SKIP    = 0
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WORDLEN-1:0]           din,
    output logic                         full,
    output logic                         ovf,
    output logic [$clog2(BUFSIZE+1)-1:0] count,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic [WORDLEN-1:0]           dout
);
    localparam int unsigned CW  = $clog2(BUFSIZE + 1);
    localparam int unsigned PW  = $clog2(BUFSIZE);
    localparam int unsigned SKW = 8;

    typedef enum logic {ST_SKIP, ST_RUN} state_t;

    state_t             state, state_nxt;
    logic [SKW-1:0]     skip_cnt, skip_nxt;
    logic [PW-1:0]      head, tail, head_nxt, tail_nxt;
    logic [CW-1:0]      count_nxt;
    logic               ovf_nxt;
    logic               pop;
    logic               store;
    logic [WORDLEN-1:0] mem [BUFSIZE];

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(BUFSIZE - 1)) ? '0 : p + PW'(1);
    endfunction

    // Status and head word come from registered state only.
    assign dout_valid = (count != '0);
    assign full       = (count == CW'(BUFSIZE));
    assign dout       = dout_valid ? mem[head] : '0;
    assign pop        = dout_valid & dout_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= (SKIP > 0) ? ST_SKIP : ST_RUN;
            skip_cnt <= SKW'(SKIP);
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_nxt;
            head     <= head_nxt;
            tail     <= tail_nxt;
            count    <= count_nxt;
            ovf      <= ovf_nxt;
        end
    end

    // Flush wins over push/pop; a full FIFO still accepts a push when a pop frees a slot.
    always_comb begin
        state_nxt = state;
        skip_nxt  = skip_cnt;
        head_nxt  = head;
        tail_nxt  = tail;
        count_nxt = count;
        ovf_nxt   = ovf;
        store     = 1'b0;
        if (flush) begin
            state_nxt = (SKIP > 0) ? ST_SKIP : ST_RUN;
            skip_nxt  = SKW'(SKIP);
            head_nxt  = '0;
            tail_nxt  = '0;
            count_nxt = '0;
            ovf_nxt   = 1'b0;
        end else begin
            case (state)
                ST_SKIP: begin
                    if (push) begin
                        skip_nxt = skip_cnt - SKW'(1);
                        if (skip_cnt == SKW'(1)) state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (push) begin
                        if (!full || pop) store = 1'b1;
                        else              ovf_nxt = 1'b1;
                    end
                end
                default: state_nxt = ST_RUN;
            endcase
            if (store) tail_nxt = wrap_inc(tail);
            if (pop)   head_nxt = wrap_inc(head);
            count_nxt = count + CW'(store) - CW'(pop);
        end
    end

    // Storage is cleared on reset only; flush leaves contents in place.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < int'(BUFSIZE); i++) mem[i] <= '0;
        end else if (store) begin
            mem[tail] <= din;
        end
    end

endmodule

// File: tb/tb_outbuf_drain.sv
// Scoreboard bench: instance a has SKIP=2, instance b has SKIP=0; both BUFSIZE=4.
module tb_outbuf_drain;
    localparam int unsigned WL = 16;
    localparam int unsigned BS = 4;
    localparam int unsigned CW = $clog2(BS + 1);

    logic clk = 1'b0;
    logic rstn;

    logic          flush_a, push_a, rdy_a, full_a, ovf_a, valid_a;
    logic [WL-1:0] din_a, dout_a;
    logic [CW-1:0] count_a;
    logic          flush_b, push_b, rdy_b, full_b, ovf_b, valid_b;
    logic [WL-1:0] din_b, dout_b;
    logic [CW-1:0] count_b;

    int n_tests = 0;
    int n_fail  = 0;
    int q_a[$];
    int q_b[$];

    always #5 clk = ~clk;

    outbuf_drain #(.WORDLEN(WL), .BUFSIZE(BS), .SKIP(2)) u_a (
        .clk(clk), .rstn(rstn), .flush(flush_a), .push(push_a), .din(din_a),
        .full(full_a), .ovf(ovf_a), .count(count_a), .dout_valid(valid_a),
        .dout_ready(rdy_a), .dout(dout_a)
    );

    outbuf_drain #(.WORDLEN(WL), .BUFSIZE(BS), .SKIP(0)) u_b (
        .clk(clk), .rstn(rstn), .flush(flush_b), .push(push_b), .din(din_b),
        .full(full_b), .ovf(ovf_b), .count(count_b), .dout_valid(valid_b),
        .dout_ready(rdy_b), .dout(dout_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic p, input int d, input logic r);
        push_a = p; din_a = WL'(d); rdy_a = r;
        tick();
    endtask

    task automatic drive_b(input logic p, input int d, input logic r);
        push_b = p; din_b = WL'(d); rdy_b = r;
        tick();
    endtask

    // Monitors: a pop happens at the coming edge, so compare the head word now.
    always @(negedge clk) begin
        if (rstn && !flush_a && valid_a && rdy_a) begin
            if (q_a.size() == 0) chk("a_unexpected_pop", int'(dout_a), -1);
            else                 chk("a_dout", int'(dout_a), q_a.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rstn && !flush_b && valid_b && rdy_b) begin
            if (q_b.size() == 0) chk("b_unexpected_pop", int'(dout_b), -1);
            else                 chk("b_dout", int'(dout_b), q_b.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        flush_a = 1'b0; push_a = 1'b0; din_a = '0; rdy_a = 1'b0;
        flush_b = 1'b0; push_b = 1'b0; din_b = '0; rdy_b = 1'b0;
        tick(); tick();
        rstn = 1'b1;

        // Reset state
        chk("rst_count_a", int'(count_a), 0);
        chk("rst_valid_a", int'(valid_a), 0);
        chk("rst_dout_a",  int'(dout_a),  0);
        chk("rst_ovf_b",   int'(ovf_b),   0);
        chk("rst_full_b",  int'(full_b),  0);

        // SKIP=2: 5,6 discarded, 7,8 drained
        q_a.push_back(7); q_a.push_back(8);
        drive_a(1'b1, 5, 1'b1); chk("skip_cnt0", int'(count_a), 0);
        drive_a(1'b1, 6, 1'b1); chk("skip_cnt1", int'(count_a), 0);
        drive_a(1'b1, 7, 1'b1); chk("skip_cnt2", int'(count_a), 1);
        chk("skip_dout7", int'(dout_a), 7);
        drive_a(1'b1, 8, 1'b1); chk("skip_cnt3", int'(count_a), 1);
        drive_a(1'b0, 0, 1'b1); chk("skip_cnt4", int'(count_a), 0);
        chk("skip_ovf", int'(ovf_a), 0);

        // SKIP=0 overflow: 1..4 stored, 5 dropped
        for (int i = 1; i <= 4; i++) begin
            q_b.push_back(i);
            drive_b(1'b1, i, 1'b0);
            chk("ovf_fill_count", int'(count_b), i);
        end
        chk("ovf_full", int'(full_b), 1);
        drive_b(1'b1, 5, 1'b0);
        chk("ovf_flag", int'(ovf_b), 1);
        chk("ovf_count", int'(count_b), 4);
        for (int i = 0; i < 4; i++) drive_b(1'b0, 0, 1'b1);
        chk("ovf_drained", int'(count_b), 0);
        chk("ovf_sticky", int'(ovf_b), 1);

        // Full FIFO with simultaneous push and pop
        flush_b = 1'b1; drive_b(1'b0, 0, 1'b0); flush_b = 1'b0;
        chk("fl_b_ovf", int'(ovf_b), 0);
        for (int i = 31; i <= 34; i++) begin
            q_b.push_back(i);
            drive_b(1'b1, i, 1'b0);
        end
        q_b.push_back(9);
        drive_b(1'b1, 9, 1'b1);
        chk("pp_count", int'(count_b), 4);
        chk("pp_ovf",   int'(ovf_b),   0);
        chk("pp_full",  int'(full_b),  1);
        for (int i = 0; i < 4; i++) drive_b(1'b0, 0, 1'b1);
        chk("pp_drained", int'(count_b), 0);

        // Streaming with one-cycle lag across pointer wraps
        for (int i = 0; i < 10; i++) begin
            q_b.push_back(100 + i);
            drive_b(1'b1, 100 + i, 1'b1);
            chk("wrap_count", int'(count_b), 1);
        end
        drive_b(1'b0, 0, 1'b1);
        chk("wrap_drained", int'(count_b), 0);

        // Ready while empty, then a single push
        for (int i = 0; i < 3; i++) begin
            drive_b(1'b0, 0, 1'b1);
            chk("empty_count", int'(count_b), 0);
            chk("empty_dout",  int'(dout_b),  0);
        end
        q_b.push_back(42);
        drive_b(1'b1, 42, 1'b1);
        chk("p42_count", int'(count_b), 1);
        chk("p42_valid", int'(valid_b), 1);
        chk("p42_dout",  int'(dout_b),  42);
        drive_b(1'b0, 0, 1'b1);
        chk("p42_drained", int'(count_b), 0);

        // Mid-stream flush with count=3 and ovf=1, then SKIP re-armed
        for (int i = 10; i <= 13; i++) drive_a(1'b1, i, 1'b0);
        drive_a(1'b1, 14, 1'b0);
        chk("fl_pre_ovf", int'(ovf_a), 1);
        q_a.push_back(10);
        drive_a(1'b0, 0, 1'b1);
        chk("fl_pre_count", int'(count_a), 3);
        flush_a = 1'b1;
        drive_a(1'b1, 99, 1'b1);
        flush_a = 1'b0;
        chk("fl_count", int'(count_a), 0);
        chk("fl_valid", int'(valid_a), 0);
        chk("fl_dout",  int'(dout_a),  0);
        chk("fl_ovf",   int'(ovf_a),   0);
        chk("fl_full",  int'(full_a),  0);
        drive_a(1'b1, 20, 1'b1); chk("rearm_cnt0", int'(count_a), 0);
        drive_a(1'b1, 21, 1'b1); chk("rearm_cnt1", int'(count_a), 0);
        q_a.push_back(22);
        drive_a(1'b1, 22, 1'b1); chk("rearm_cnt2", int'(count_a), 1);
        chk("rearm_dout", int'(dout_a), 22);
        drive_a(1'b0, 0, 1'b1);
        chk("rearm_drained", int'(count_a), 0);

        tick();
        chk("q_a_empty", q_a.size(), 0);
        chk("q_b_empty", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
